// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_muldiv execute-stage datapath.
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  // Fill bit for the divide-by-zero quotient; replicated to the datapath width.
  localparam logic DIV0_QUOT = 1'b1;

  typedef enum logic [ALU_CTRL_W-1:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLT   = 4'b0101,
    OP_SLTU  = 4'b0110,
    OP_SLL   = 4'b0111,
    OP_SRL   = 4'b1000,
    OP_SRA   = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_REMU  = 4'b1101,
    OP_RSV0  = 4'b1110,
    OP_RSV1  = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } alu_state_e;

  // Ops that go through the WIDTH-step shift/subtract engine.
  function automatic logic is_iter_op(input alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Unsigned shift-add multiplier / restoring divider sharing one 2*WIDTH register.
// Multiply: {hi,lo} starts as {0, op1}; each step adds op2 into hi when lo[0]
// is set and shifts the whole register right. Divide: {rem,quot} starts as
// {0, op1}; each step shifts left and subtracts op2 from rem when it fits.
// A zero divisor naturally yields an all-ones quotient and rem = dividend.
// lo/hi present the value after the current step so the parent can capture
// the final result on the same edge that done is high.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;
  logic               div_q, div_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   quo_sh;
  logic [2*WIDTH-1:0] step;

  // One multiply or divide iteration applied to the current register.
  always_comb begin
    sum    = '0;
    rem_sh = '0;
    quo_sh = '0;
    step   = acc_q;
    if (div_q) begin
      rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      quo_sh = {acc_q[WIDTH-2:0], 1'b0};
      if (rem_sh >= {1'b0, m_q}) begin
        rem_sh    = rem_sh - {1'b0, m_q};
        quo_sh[0] = 1'b1;
      end
      step = {rem_sh[WIDTH-1:0], quo_sh};
    end else begin
      sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
      step = {sum, acc_q[WIDTH-1:1]};
    end
  end

  // Load on start, then step with a down-counter until terminal count.
  always_comb begin
    acc_d = acc_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    run_d = run_q;
    div_d = div_q;
    if (start) begin
      acc_d = {{WIDTH{1'b0}}, op1};
      m_d   = op2;
      cnt_d = CNT_W'(WIDTH - 1);
      run_d = 1'b1;
      div_d = is_div;
    end else if (run_q) begin
      acc_d = step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end
    end
  end

  // Engine state registers; reset clears the counter and abandons any op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      div_q <= div_d;
    end
  end

  assign done = run_q && (cnt_q == '0);
  assign lo   = step[WIDTH-1:0];
  assign hi   = step[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with iterative unsigned multiply/divide behind valid/ready.
//
//   state | meaning
//   IDLE  | waiting for a request; in_ready high
//   CALC  | muldiv engine stepping one bit per cycle; busy high
//   DONE  | result held; out_valid rises one cycle after entry, leave on out_ready
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      alu_op1,
  input  logic [WIDTH-1:0]      reg_op2,
  input  logic [WIDTH-1:0]      imm_op,
  input  logic                  alu_src,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      alu_out,
  output logic                  eq,
  output logic                  busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, op_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             eq_q, eq_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  alu_op_e          op_in;
  logic [WIDTH-1:0] op2;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] sc_result;
  logic [WIDTH-1:0] md_result;
  logic             md_start, md_is_div, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign op_in     = alu_op_e'(alu_ctrl);
  assign op2       = alu_src ? imm_op : reg_op2;
  assign shamt     = op2[SHAMT_W-1:0];
  assign md_is_div = (op_in == OP_DIVU) || (op_in == OP_REMU);
  assign md_start  = (state_q == ST_IDLE) && in_valid && is_iter_op(op_in);

  // Single-cycle datapath on the live operands; only sampled at the accept edge.
  always_comb begin
    sc_result = '0;
    case (op_in)
      OP_ADD:  sc_result = alu_op1 + op2;
      OP_SUB:  sc_result = alu_op1 - op2;
      OP_AND:  sc_result = alu_op1 & op2;
      OP_OR:   sc_result = alu_op1 | op2;
      OP_XOR:  sc_result = alu_op1 ^ op2;
      OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(alu_op1) < $signed(op2))};
      OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (alu_op1 < op2)};
      OP_SLL:  sc_result = alu_op1 << shamt;
      OP_SRL:  sc_result = alu_op1 >> shamt;
      OP_SRA:  sc_result = $signed(alu_op1) >>> shamt;
      default: sc_result = '0;
    endcase
  end

  // Pick the engine half that belongs to the latched iterative op.
  always_comb begin
    md_result = md_hi;
    case (op_q)
      OP_MUL:   md_result = md_lo;
      OP_MULHU: md_result = md_hi;
      OP_DIVU:  md_result = div0_q ? {WIDTH{DIV0_QUOT}} : md_lo;
      default:  md_result = md_hi;
    endcase
  end

  // Next-state and registered-output logic for the handshake FSM.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    div0_d    = div0_q;
    alu_out_d = alu_out_q;
    eq_d      = eq_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d   = op_in;
          div0_d = (op2 == '0);
          if (is_iter_op(op_in)) begin
            state_d = ST_CALC;
          end else begin
            alu_out_d = sc_result;
            eq_d      = (sc_result == '0);
            state_d   = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        if (md_done) begin
          alu_out_d = md_result;
          eq_d      = (md_result == '0);
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_q == ST_DONE) && (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_CALC);
  end

  // FSM state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      div0_q      <= 1'b0;
      alu_out_q   <= '0;
      eq_q        <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      div0_q      <= div0_d;
      alu_out_q   <= alu_out_d;
      eq_q        <= eq_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .is_div (md_is_div),
    .op1    (alu_op1),
    .op2    (op2),
    .done   (md_done),
    .lo     (md_lo),
    .hi     (md_hi)
  );

  assign alu_out   = alu_out_q;
  assign eq        = eq_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: 32-bit instance plus an 8-bit build.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] alu_op1 = '0;
  logic [W-1:0] reg_op2 = '0;
  logic [W-1:0] imm_op = '0;
  logic         alu_src = 1'b0;
  logic [3:0]   alu_ctrl = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] alu_out;
  logic         eq;
  logic         busy;

  logic         in_valid8 = 1'b0;
  logic         in_ready8;
  logic [7:0]   op1_8 = '0;
  logic [7:0]   op2_8 = '0;
  logic [7:0]   imm_8 = '0;
  logic [3:0]   ctrl8 = '0;
  logic         out_valid8;
  logic         out_ready8 = 1'b0;
  logic [7:0]   out8;
  logic         eq8;
  logic         busy8;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   exp8_q[$];

  alu_muldiv #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op1   (alu_op1),
    .reg_op2   (reg_op2),
    .imm_op    (imm_op),
    .alu_src   (alu_src),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .eq        (eq),
    .busy      (busy)
  );

  alu_muldiv #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .alu_op1   (op1_8),
    .reg_op2   (op2_8),
    .imm_op    (imm_8),
    .alu_src   (1'b0),
    .alu_ctrl  (ctrl8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .alu_out   (out8),
    .eq        (eq8),
    .busy      (busy8)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (c)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'd6:  return (a < b) ? W'(1) : W'(0);
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return $signed(a) >>> b[4:0];
      4'd10: return p[W-1:0];
      4'd11: return p[2*W-1:W];
      4'd12: return (b == '0) ? {W{1'b1}} : a / b;
      4'd13: return (b == '0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic src, input int hold, input bit poke);
    int exp_lat, lat, busy_n, k;
    logic [W-1:0] exp;
    bit iter;
    iter    = (c >= 4'd10) && (c <= 4'd13);
    exp_lat = iter ? W + 1 : 1;
    alu_op1  = a;
    alu_ctrl = c;
    alu_src  = src;
    if (src) begin
      imm_op  = b;
      reg_op2 = ~b;
    end else begin
      reg_op2 = b;
      imm_op  = ~b;
    end
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_val({tag, "_rdy"}, in_ready, 1);
    @(posedge clk);
    exp_q.push_back(model(c, a, b));
    #1;
    in_valid = 1'b0;
    alu_op1  = $urandom;
    reg_op2  = $urandom;
    imm_op   = $urandom;
    alu_ctrl = 4'($urandom);
    busy_n   = busy ? 1 : 0;
    lat      = -1;
    for (int i = 1; i <= W + 10; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_n++;
      in_valid = poke && busy && (i % 3 == 0);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    in_valid = 1'b0;
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_busy"}, busy_n, iter ? W : 0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check_val({tag, "_out"}, alu_out, exp);
    check_val({tag, "_eq"}, eq, (exp == '0));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_val({tag, "_hold_out"}, alu_out, exp);
      check_val({tag, "_hold_vld"}, out_valid, 1);
      check_val({tag, "_hold_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val({tag, "_idle_rdy"}, in_ready, 1);
    check_val({tag, "_idle_vld"}, out_valid, 0);
  endtask

  task automatic run8(input string tag, input logic [3:0] c, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp_val);
    int lat;
    logic [7:0] exp;
    op1_8 = a;
    op2_8 = b;
    ctrl8 = c;
    in_valid8 = 1'b1;
    @(negedge clk);
    check_val({tag, "_rdy"}, in_ready8, 1);
    @(posedge clk);
    exp8_q.push_back(exp_val);
    #1;
    in_valid8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid8) begin
        lat = i;
        break;
      end
    end
    check_val({tag, "_lat"}, lat, 9);
    exp = (exp8_q.size() > 0) ? exp8_q.pop_front() : '0;
    check_val({tag, "_out"}, out8, exp);
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [3:0] rc;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_vld", out_valid, 0);
    check_val("rst_out", alu_out, 0);
    check_val("rst_eq", eq, 0);
    check_val("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_rdy", in_ready, 1);

    run_op("add",   4'd0,  32'd5,          32'd7,          1'b0, 0, 0);
    run_op("sub",   4'd1,  32'd9,          32'd9,          1'b0, 0, 0);
    run_op("slt",   4'd5,  32'hFFFF_FFFF,  32'd1,          1'b1, 0, 0);
    run_op("sltu",  4'd6,  32'hFFFF_FFFF,  32'd1,          1'b1, 0, 0);
    run_op("sra",   4'd9,  32'h8000_0000,  32'd4,          1'b1, 0, 0);
    run_op("sll33", 4'd7,  32'h4000_0001,  32'd33,         1'b1, 0, 0);
    run_op("srl",   4'd8,  32'h8000_0010,  32'd4,          1'b0, 0, 0);
    run_op("xor",   4'd4,  32'hA5A5_0F0F,  32'h5A5A_0F0F,  1'b0, 0, 0);
    run_op("rsv14", 4'd14, 32'd5,          32'd6,          1'b0, 0, 0);
    run_op("rsv15", 4'd15, 32'd5,          32'd6,          1'b1, 0, 0);
    run_op("mul",   4'd10, 32'hFFFF_FFFF,  32'd2,          1'b0, 0, 1);
    run_op("mulhu", 4'd11, 32'hFFFF_FFFF,  32'd2,          1'b0, 0, 1);
    run_op("mulh0", 4'd11, 32'd0,          32'h1234_5678,  1'b0, 0, 0);
    run_op("divu",  4'd12, 32'd100,        32'd7,          1'b0, 0, 0);
    run_op("remu",  4'd13, 32'd100,        32'd7,          1'b0, 0, 0);
    run_op("div0",  4'd12, 32'd5,          32'd0,          1'b0, 0, 0);
    run_op("rem0",  4'd13, 32'd5,          32'd0,          1'b1, 0, 0);
    run_op("bp",    4'd0,  32'd3,          32'd4,          1'b0, 5, 0);
    run_op("bpdiv", 4'd12, 32'hFFFF_0000,  32'd3,          1'b0, 3, 0);

    for (int i = 0; i < 10; i++) begin
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = (i == 3) ? '0 : W'($urandom);
      run_op("rand", rc, ra, rb, 1'($urandom), 0, 0);
    end

    // Reset during the 10th cycle of a MUL.
    alu_op1  = 32'hFFFF_FFFF;
    reg_op2  = 32'd2;
    alu_src  = 1'b0;
    alu_ctrl = 4'd10;
    in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_val("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_val("mid_busy_clr", busy, 0);
    @(posedge clk);
    #1;
    check_val("mid_rdy", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_val("mid_no_vld", seen, 0);
    run_op("add11", 4'd0, 32'd1, 32'd1, 1'b0, 0, 0);

    run8("w8_mul",   4'd10, 8'hFF, 8'hFF, 8'h01);
    run8("w8_mulhu", 4'd11, 8'hFF, 8'hFF, 8'hFE);
    run8("w8_divu",  4'd12, 8'd200, 8'd9, 8'd22);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
